// File: rtl/vmewrite_pkg.sv
// Shared definitions for the VME write-side register bank: register map,
// FSM state encoding and the address decoder.
package vmewrite_pkg;

  localparam int NREG = 13;

  localparam logic [15:0] A7C80 = 16'h7C80;
  localparam logic [15:0] A7C82 = 16'h7C82;
  localparam logic [15:0] A7C84 = 16'h7C84;
  localparam logic [15:0] A7C86 = 16'h7C86;
  localparam logic [15:0] A7C88 = 16'h7C88;
  localparam logic [15:0] A7C8A = 16'h7C8A;
  localparam logic [15:0] A7C8C = 16'h7C8C;
  localparam logic [15:0] A7C8E = 16'h7C8E;
  localparam logic [15:0] A7C90 = 16'h7C90;
  localparam logic [15:0] A7C96 = 16'h7C96;
  localparam logic [15:0] A7CA0 = 16'h7CA0;
  localparam logic [15:0] A7CA2 = 16'h7CA2;
  localparam logic [15:0] A7CA4 = 16'h7CA4;

  // Entry i is register i; WSTB bit order follows this table.
  localparam logic [NREG-1:0][15:0] REG_ADDR = {
    A7CA4, A7CA2, A7CA0, A7C96, A7C90, A7C8E, A7C8C,
    A7C8A, A7C88, A7C86, A7C84, A7C82, A7C80
  };

  typedef enum logic [2:0] {
    IDLE, DECODE, WAITDS, WRITE, ACK, RELEASE, IGNORE
  } state_t;

  // Word address compare: bit 0 is forced to 1 on both sides so it never matters.
  function automatic logic [NREG-1:0] decode(input logic [15:0] addr);
    logic [NREG-1:0] hit;
    hit = '0;
    for (int i = 0; i < NREG; i++) begin
      hit[i] = ((addr | 16'h0001) == (REG_ADDR[i] | 16'h0001));
    end
    return hit;
  endfunction

endpackage

// File: rtl/vmesync.sv
// Multi-flop synchronizer for an active-low VME strobe; resets to inactive (1).
module vmesync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_reg;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/vmewrite.sv
// VME A16 write slave: handshake FSM, address decode and 13-register bank.
// Optional build macro VMEWRITE_BYTESWAP_EN stores DIN byte-swapped.
module vmewrite
  import vmewrite_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic [15:0]     ADDR,
  input  logic [15:0]     DIN,
  input  logic            AS_N,
  input  logic            DS_N,
  input  logic            WRITE_N,
  output logic            DTACK_N,
  output logic [15:0]     REG7C80,
  output logic [15:0]     REG7C82,
  output logic [15:0]     REG7C84,
  output logic [15:0]     REG7C86,
  output logic [15:0]     REG7C88,
  output logic [15:0]     REG7C8A,
  output logic [15:0]     REG7C8C,
  output logic [15:0]     REG7C8E,
  output logic [15:0]     REG7C90,
  output logic [15:0]     REG7C96,
  output logic [15:0]     REG7CA0,
  output logic [15:0]     REG7CA2,
  output logic [15:0]     REG7CA4,
  output logic [NREG-1:0] WSTB,
  output logic            BUSY
);

  logic as_s;
  logic ds_s;
  logic wr_s;

  vmesync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_as (.CLK(CLK), .RSTN(RSTN), .d(AS_N),    .q(as_s));
  vmesync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ds (.CLK(CLK), .RSTN(RSTN), .d(DS_N),    .q(ds_s));
  vmesync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_wr (.CLK(CLK), .RSTN(RSTN), .d(WRITE_N), .q(wr_s));

  state_t                 state_reg, state_next;
  logic [SYNC_STAGES-1:0] fill_reg;
  logic                   fill_done;
  logic                   armed_reg;
  logic [15:0]            addr_reg;
  logic [NREG-1:0]        sel_reg;
  logic [NREG-1:0][15:0]  regs_reg;
  logic [NREG-1:0]        wstb_reg;
  logic                   dtack_n_reg;

  logic                   load;
  logic                   latch_addr;
  logic [NREG-1:0]        wstb_next;
  logic                   dtack_n_next;
  logic [15:0]            wdata;

`ifdef VMEWRITE_BYTESWAP_EN
  assign wdata = {DIN[7:0], DIN[15:8]};
`else
  assign wdata = DIN;
`endif

  // The synchronizers read "inactive" right after reset; fill_done marks when
  // they carry real bus samples, so a strobe held through reset is not a new cycle.
  assign fill_done = fill_reg[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (!armed_reg) begin
          if (fill_done && !as_s) state_next = IGNORE;
        end else if (!as_s) begin
          state_next = wr_s ? IGNORE : DECODE;
        end
      end
      DECODE:  state_next = (|decode(addr_reg)) ? WAITDS : IGNORE;
      WAITDS: begin
        if (as_s)       state_next = IDLE;
        else if (!ds_s) state_next = WRITE;
      end
      WRITE:   state_next = ACK;
      ACK:     if (ds_s) state_next = RELEASE;
      RELEASE: if (as_s) state_next = IDLE;
      IGNORE:  if (as_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    latch_addr   = (state_reg == IDLE) && (state_next == DECODE);
    load         = (state_reg == WAITDS) && (state_next == WRITE);
    wstb_next    = load ? sel_reg : '0;
    dtack_n_next = (state_next != ACK);
    BUSY         = (state_reg != IDLE);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fill_reg    <= '0;
      armed_reg   <= 1'b0;
      addr_reg    <= '0;
      sel_reg     <= '0;
      regs_reg    <= '0;
      wstb_reg    <= '0;
      dtack_n_reg <= 1'b1;
    end else begin
      fill_reg    <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
      armed_reg   <= armed_reg | (fill_done & as_s);
      wstb_reg    <= wstb_next;
      dtack_n_reg <= dtack_n_next;
      if (latch_addr) addr_reg <= ADDR;
      if (state_reg == DECODE) sel_reg <= decode(addr_reg);
      for (int i = 0; i < NREG; i++) begin
        if (load && sel_reg[i]) regs_reg[i] <= wdata;
      end
    end
  end

  assign DTACK_N = dtack_n_reg;
  assign WSTB    = wstb_reg;
  assign REG7C80 = regs_reg[0];
  assign REG7C82 = regs_reg[1];
  assign REG7C84 = regs_reg[2];
  assign REG7C86 = regs_reg[3];
  assign REG7C88 = regs_reg[4];
  assign REG7C8A = regs_reg[5];
  assign REG7C8C = regs_reg[6];
  assign REG7C8E = regs_reg[7];
  assign REG7C90 = regs_reg[8];
  assign REG7C96 = regs_reg[9];
  assign REG7CA0 = regs_reg[10];
  assign REG7CA2 = regs_reg[11];
  assign REG7CA4 = regs_reg[12];

endmodule

// File: tb/tb_vmewrite.sv
// Randomized scoreboard bench for vmewrite: VME cycles are driven by tasks,
// expected writes are queued and a monitor checks every WSTB pulse.
module tb_vmewrite;

  localparam int SYNC_STAGES = 2;
  localparam int NREG = 13;

  logic            CLK = 1'b0;
  logic            RSTN = 1'b0;
  logic [15:0]     ADDR = '0;
  logic [15:0]     DIN = '0;
  logic            AS_N = 1'b1;
  logic            DS_N = 1'b1;
  logic            WRITE_N = 1'b1;
  logic            DTACK_N;
  logic [15:0]     REG7C80, REG7C82, REG7C84, REG7C86, REG7C88, REG7C8A, REG7C8C;
  logic [15:0]     REG7C8E, REG7C90, REG7C96, REG7CA0, REG7CA2, REG7CA4;
  logic [NREG-1:0] WSTB;
  logic            BUSY;

  vmewrite #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(CLK), .RSTN(RSTN), .ADDR(ADDR), .DIN(DIN),
    .AS_N(AS_N), .DS_N(DS_N), .WRITE_N(WRITE_N), .DTACK_N(DTACK_N),
    .REG7C80(REG7C80), .REG7C82(REG7C82), .REG7C84(REG7C84), .REG7C86(REG7C86),
    .REG7C88(REG7C88), .REG7C8A(REG7C8A), .REG7C8C(REG7C8C), .REG7C8E(REG7C8E),
    .REG7C90(REG7C90), .REG7C96(REG7C96), .REG7CA0(REG7CA0), .REG7CA2(REG7CA2),
    .REG7CA4(REG7CA4), .WSTB(WSTB), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  logic [15:0] regs_w [NREG];
  assign regs_w[0]  = REG7C80;
  assign regs_w[1]  = REG7C82;
  assign regs_w[2]  = REG7C84;
  assign regs_w[3]  = REG7C86;
  assign regs_w[4]  = REG7C88;
  assign regs_w[5]  = REG7C8A;
  assign regs_w[6]  = REG7C8C;
  assign regs_w[7]  = REG7C8E;
  assign regs_w[8]  = REG7C90;
  assign regs_w[9]  = REG7C96;
  assign regs_w[10] = REG7CA0;
  assign regs_w[11] = REG7CA2;
  assign regs_w[12] = REG7CA4;

  logic [15:0] map_addr [NREG] = '{
    16'h7C80, 16'h7C82, 16'h7C84, 16'h7C86, 16'h7C88, 16'h7C8A, 16'h7C8C,
    16'h7C8E, 16'h7C90, 16'h7C96, 16'h7CA0, 16'h7CA2, 16'h7CA4
  };

  typedef struct {
    int          idx;
    logic [15:0] data;
  } exp_t;

  logic [15:0] model [NREG];
  exp_t        sb_q [$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  bit          ack_allowed = 1'b0;

  function automatic int idx_of(input logic [15:0] a);
    for (int i = 0; i < NREG; i++) begin
      if (a[15:1] == map_addr[i][15:1]) return i;
    end
    return -1;
  endfunction

  function automatic logic [15:0] stored(input logic [15:0] d);
`ifdef VMEWRITE_BYTESWAP_EN
    return {d[7:0], d[15:8]};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every WSTB pulse must match the oldest queued write.
  always @(negedge CLK) begin
    if (RSTN) begin
      if (!DTACK_N && !ack_allowed) chk("dtack_unexpected", 32'(DTACK_N), 32'd1);
      if (WSTB != '0) begin
        if (sb_q.size() == 0) begin
          chk("wstb_unexpected", 32'(WSTB), 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("wstb_onehot", 32'(WSTB), 32'd1 << mon_e.idx);
          chk("reg_value", 32'(regs_w[mon_e.idx]), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic vme_cycle(input logic [15:0] a, input logic [15:0] d, input bit wr);
    int idx;
    int n;
    bit hit;
    idx = idx_of(a);
    hit = wr && (idx >= 0);
    @(posedge CLK); #3;
    ADDR = a; DIN = d; WRITE_N = !wr;
    @(posedge CLK); #3;
    AS_N = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    if (hit) begin
      model[idx] = stored(d);
      sb_q.push_back('{idx, stored(d)});
      ack_allowed = 1'b1;
    end
    DS_N = 1'b0;
    if (hit) begin
      n = 0;
      do begin @(posedge CLK); #1; n++; end while (DTACK_N && n < 20);
      chk("dtack_fall_latency", 32'(n), 32'(SYNC_STAGES + 2));
      #2;
      DS_N = 1'b1;
      n = 0;
      do begin @(posedge CLK); #1; n++; end while (!DTACK_N && n < 20);
      chk("dtack_rise_latency", 32'(n), 32'(SYNC_STAGES + 1));
      ack_allowed = 1'b0;
    end else begin
      repeat (8) @(posedge CLK);
      #3;
      DS_N = 1'b1;
      repeat (2) @(posedge CLK);
    end
    @(posedge CLK); #3;
    AS_N = 1'b1; WRITE_N = 1'b1;
    repeat (SYNC_STAGES + 3) @(posedge CLK);
    #1;
    chk("busy_after_cycle", 32'(BUSY), 32'd0);
    $display("txn addr=%h data=%h wr=%0d mapped_write=%0d", a, d, wr, hit);
  endtask

  task automatic check_all_regs(input string name);
    for (int i = 0; i < NREG; i++) chk(name, 32'(regs_w[i]), 32'(model[i]));
  endtask

  initial begin
    int n;
    for (int i = 0; i < NREG; i++) model[i] = '0;

    repeat (3) @(posedge CLK);
    #3 RSTN = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    check_all_regs("reset_reg");
    chk("reset_dtack", 32'(DTACK_N), 32'd1);
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_wstb", 32'(WSTB), 32'd0);
    $display("txn reset released");

    vme_cycle(16'h7C84, 16'h1234, 1'b1);
    chk("reg7c84_value", 32'(REG7C84), 32'(stored(16'h1234)));

    vme_cycle(16'h7C92, 16'(($urandom)), 1'b1);
    vme_cycle(16'h7C80, 16'(($urandom)), 1'b0);
    check_all_regs("unmapped_or_read_reg");

    // Aborted cycle: AS released before DS ever falls
    @(posedge CLK); #3;
    ADDR = 16'h7CA0; DIN = 16'hDEAD; WRITE_N = 1'b0;
    @(posedge CLK); #3;
    AS_N = 1'b0;
    repeat (6) @(posedge CLK);
    #3;
    AS_N = 1'b1; WRITE_N = 1'b1;
    repeat (SYNC_STAGES + 3) @(posedge CLK);
    #1;
    chk("abort_reg7ca0", 32'(REG7CA0), 32'(model[10]));
    chk("abort_busy", 32'(BUSY), 32'd0);
    $display("txn abort addr=7ca0");

    // Reset while acknowledging a write, strobes still held low at release
    @(posedge CLK); #3;
    ADDR = 16'h7C96; DIN = 16'hBEEF; WRITE_N = 1'b0;
    @(posedge CLK); #3;
    AS_N = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    sb_q.push_back('{9, stored(16'hBEEF)});
    ack_allowed = 1'b1;
    DS_N = 1'b0;
    n = 0;
    do begin @(posedge CLK); #1; n++; end while (DTACK_N && n < 20);
    chk("midreset_dtack_fall", 32'(n), 32'(SYNC_STAGES + 2));
    chk("midreset_written", 32'(REG7C96), 32'(stored(16'hBEEF)));
    #2;
    RSTN = 1'b0;
    #1;
    ack_allowed = 1'b0;
    for (int i = 0; i < NREG; i++) model[i] = '0;
    chk("midreset_dtack", 32'(DTACK_N), 32'd1);
    chk("midreset_reg7c96", 32'(REG7C96), 32'd0);
    chk("midreset_wstb", 32'(WSTB), 32'd0);
    chk("midreset_busy", 32'(BUSY), 32'd0);
    repeat (3) @(posedge CLK);
    #3 RSTN = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("post_reset_ignore_busy", 32'(BUSY), 32'd1);
    chk("post_reset_dtack", 32'(DTACK_N), 32'd1);
    check_all_regs("post_reset_reg");
    #2;
    DS_N = 1'b1; AS_N = 1'b1; WRITE_N = 1'b1;
    repeat (SYNC_STAGES + 3) @(posedge CLK);
    #1;
    chk("post_reset_idle", 32'(BUSY), 32'd0);
    $display("txn reset during ack on 7c96");
    vme_cycle(16'h7C96, 16'hBEEF, 1'b1);

    for (int i = 0; i < NREG; i++) vme_cycle(map_addr[i], 16'(i + 1), 1'b1);
    check_all_regs("b2b_reg");

    for (int k = 0; k < 40; k++) begin
      logic [15:0] a;
      if ($urandom_range(0, 1) == 1) a = map_addr[$urandom_range(0, NREG - 1)] | 16'($urandom_range(0, 1));
      else a = 16'h7C80 + 16'(2 * $urandom_range(0, 23));
      vme_cycle(a, 16'($urandom), $urandom_range(0, 3) != 0);
    end
    check_all_regs("final_reg");
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmewrite.md
# vmewrite

Write-side VME slave register bank: the counterpart of the read multiplexer on the same 0x7C80–0x7CA4 register map. Runs the VME write handshake (AS*/DS*/WRITE* in, DTACK* out), decodes the 16-bit address, and stores write data into the 13 mapped 16-bit registers. It also emits a one-cycle write strobe per register to downstream logic. Read cycles are ignored here; they are served by the read mux and its own acknowledge path.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for AS_N/DS_N/WRITE_N (min 2).

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- ADDR  in  16  VME address (A16 word address, bit0 ignored).
- DIN  in  16  VME write data.
- AS_N  in  1  address strobe, active low, asynchronous to CLK.
- DS_N  in  1  data strobe, active low (DS0*&DS1* combined upstream), asynchronous.
- WRITE_N  in  1  low = write cycle.
- DTACK_N  out  1  data acknowledge, active low.
- REG7C80, REG7C82, REG7C84, REG7C86, REG7C88, REG7C8A, REG7C8C, REG7C8E, REG7C90, REG7C96, REG7CA0, REG7CA2, REG7CA4  out  16 each  stored register values.
- WSTB  out  13  one-hot write pulse, bit i = register i in the order listed above.
- BUSY  out  1  high whenever FSM is not IDLE.

## Operation
- AS_N, DS_N, WRITE_N pass through SYNC_STAGES flops; FSM sees only synchronized copies. ADDR/DIN are sampled only after a synchronized strobe, and are treated as stable by then.
- **IDLE**: on synced AS low and synced WRITE_N low, latch ADDR, go to DECODE. If WRITE_N is high (read), go to IGNORE.
- **DECODE** (1 cycle): compare the latched address against the 13 map entries.
  - Hit: go to WAITDS.
  - Miss: go to IGNORE. No DTACK is driven, so the system bus timer raises BERR.
- **WAITDS**: wait for synced DS low, then latch DIN and go to WRITE. If synced AS returns high first (aborted cycle), go to IDLE with no write.
- **WRITE** (1 cycle): update the selected register, pulse its WSTB bit, go to ACK.
- **ACK**: drive DTACK_N low. Hold until synced DS high, then go to RELEASE.
- **RELEASE**: DTACK_N high. Return to IDLE when synced AS is high.
- **IGNORE**: wait for synced AS high, then IDLE. Never writes, never acks.
- Exactly one register is written per VME cycle. Back-to-back cycles need AS to go high in between.
- Reset asserted mid-cycle:
  - All registers go to 0, DTACK_N to 1, WSTB to 0, state to IDLE.
  - After reset release, a strobe still held low is not treated as a new cycle. The FSM first requires synced AS high (it enters IGNORE if AS is low at reset exit).

## Timing
- Reset values: all REGxxxx = 16'h0000, DTACK_N = 1, WSTB = 0, BUSY = 0.
- Write latency from the DS_N falling edge: SYNC_STAGES + 1 cycles to register update (WSTB high in that same cycle). DTACK_N falls on the following edge.
- DTACK_N rises SYNC_STAGES + 1 cycles after DS_N rises.
- WSTB is high for exactly 1 cycle per accepted write. The REG value is updated on the same edge WSTB rises.
- DIN is latched on the cycle WAITDS exits and must be stable from DS_N fall until DTACK_N fall.
- Simultaneous AS rise and DS fall in WAITDS: AS has priority, and the cycle aborts.

## Configuration
- VMEWRITE_BYTESWAP_EN:
  - Defined: stored data = {DIN[7:0], DIN[15:8]}, matching the byte-swapped status convention used on reads.
  - Undefined: stored data = DIN unchanged.
  - Strobe and handshake timing are identical in both builds.

## Structure
- Package vmewrite_pkg holds:
  - the 13 address localparams (16'h7C80 … 16'h7CA4) and NREG = 13;
  - the state enum {IDLE, DECODE, WAITDS, WRITE, ACK, RELEASE, IGNORE};
  - a decode function: address → one-hot [12:0].
- Sub-module vmesync: a parameterized SYNC_STAGES flop chain with reset value 1 (inactive), instantiated for each of AS_N, DS_N and WRITE_N.

## Test plan
- Reset check: release RSTN with strobes idle → all REG = 0, DTACK_N = 1, BUSY = 0.
- Mapped write: write 16'h1234 to 7C84 → REG7C84 = 16'h1234, WSTB = 13'b0000000000100 for 1 cycle, DTACK_N low SYNC_STAGES+2 cycles after DS fall, high after DS release. Byteswap build gives 16'h3412.
- Unmapped / read cycle: write to 7C92, then read from 7C80 → DTACK_N stays 1, no WSTB, all registers unchanged, FSM back in IDLE after AS high.
- Abort: AS low, then AS high before DS ever falls, on address 7CA0 → REG7CA0 unchanged, no DTACK.
- Reset mid-cycle: assert RSTN low while in ACK after writing 16'hBEEF to 7C96 → REG7C96 = 0, DTACK_N = 1 immediately. With AS still low at release → no write until AS goes high and a new cycle starts.
- Back-to-back: writes of 16'h0001…16'h000D to all 13 addresses in sequence → each register holds its value, 13 single-cycle WSTB pulses in order.
